// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - hazard stall/flush and HI/LO multiply-divide sequencer (optional PIPE_STALL_CNT_EN stall counter)
module pipe_stall_ctrl #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rs_D,
    input  logic [4:0] rt_D,
    input  logic [1:0] tuse_rs_D,
    input  logic [1:0] tuse_rt_D,
    input  logic       md_D,
    input  logic [4:0] dst_E,
    input  logic [1:0] tnew_E,
    input  logic [4:0] dst_M,
    input  logic [1:0] tnew_M,
    input  logic       md_start_E,
    input  logic       md_op_E,
    output logic       stall,
    output logic       flush_E,
    output logic       md_busy,
    output logic       md_done
`ifdef PIPE_STALL_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             haz_rs;
    logic             haz_rt;
    logic             haz_md;

    // A source conflicts only if the producer's result arrives later than the consumer needs it.
    assign haz_rs = (rs_D != 5'd0) &&
                    (((rs_D == dst_E) && (tnew_E > tuse_rs_D)) ||
                     ((rs_D == dst_M) && (tnew_M > tuse_rs_D)));
    assign haz_rt = (rt_D != 5'd0) &&
                    (((rt_D == dst_E) && (tnew_E > tuse_rt_D)) ||
                     ((rt_D == dst_M) && (tnew_M > tuse_rt_D)));
    assign haz_md = md_D && (md_busy || md_start_E);

    assign stall   = haz_rs || haz_rt || haz_md;
    assign flush_E = stall;

    assign md_busy = (state == BUSY);
    assign md_done = (state == BUSY) && (cnt == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (md_start_E) begin
                        cnt   <= md_op_E ? DIV_CNT : MULT_CNT;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    // Starts arriving while busy are dropped; decode stalls keep them from happening.
                    if (cnt == CNT_W'(1)) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef PIPE_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (stall) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb/tb_pipe_stall_ctrl.sv - table-driven and sequence checks for pipe_stall_ctrl
module tb_pipe_stall_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs_D, rt_D, dst_E, dst_M;
    logic [1:0] tuse_rs_D, tuse_rt_D, tnew_E, tnew_M;
    logic       md_D, md_start_E, md_op_E;
    logic       stall, flush_E, md_busy, md_done;
`ifdef PIPE_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipe_stall_ctrl #(.MULT_LAT(5), .DIV_LAT(10), .CNT_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .rs_D       (rs_D),
        .rt_D       (rt_D),
        .tuse_rs_D  (tuse_rs_D),
        .tuse_rt_D  (tuse_rt_D),
        .md_D       (md_D),
        .dst_E      (dst_E),
        .tnew_E     (tnew_E),
        .dst_M      (dst_M),
        .tnew_M     (tnew_M),
        .md_start_E (md_start_E),
        .md_op_E    (md_op_E),
        .stall      (stall),
        .flush_E    (flush_E),
        .md_busy    (md_busy),
        .md_done    (md_done)
`ifdef PIPE_STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [1:0] tuse_rs;
        logic [1:0] tuse_rt;
        logic       md;
        logic [4:0] de;
        logic [1:0] te;
        logic [4:0] dm;
        logic [1:0] tm;
        logic       start;
        logic       exp_stall;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt,
                                input logic [1:0] urs, input logic [1:0] urt,
                                input logic md, input logic [4:0] de, input logic [1:0] te,
                                input logic [4:0] dm, input logic [1:0] tm,
                                input logic start, input logic exp_stall);
        vec_t v;
        v.rs = rs; v.rt = rt; v.tuse_rs = urs; v.tuse_rt = urt; v.md = md;
        v.de = de; v.te = te; v.dm = dm; v.tm = tm; v.start = start; v.exp_stall = exp_stall;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        rs_D = 0; rt_D = 0; tuse_rs_D = 2'd3; tuse_rt_D = 2'd3; md_D = 0;
        dst_E = 0; tnew_E = 0; dst_M = 0; tnew_M = 0; md_start_E = 0; md_op_E = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_load_use();
        rs_D = 5'd8; tuse_rs_D = 2'd1; dst_E = 5'd8; tnew_E = 2'd2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mk(5'd8, 5'd0, 2'd1, 2'd3, 1'b0, 5'd8, 2'd2, 5'd0, 2'd0, 1'b0, 1'b1);
        vecs[1]  = mk(5'd8, 5'd0, 2'd1, 2'd3, 1'b0, 5'd8, 2'd1, 5'd0, 2'd0, 1'b0, 1'b0);
        vecs[2]  = mk(5'd0, 5'd0, 2'd0, 2'd3, 1'b0, 5'd0, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0);
        vecs[3]  = mk(5'd0, 5'd9, 2'd3, 2'd3, 1'b0, 5'd0, 2'd0, 5'd9, 2'd1, 1'b0, 1'b0);
        vecs[4]  = mk(5'd0, 5'd9, 2'd3, 2'd0, 1'b0, 5'd0, 2'd0, 5'd9, 2'd1, 1'b0, 1'b1);
        vecs[5]  = mk(5'd0, 5'd9, 2'd3, 2'd1, 1'b0, 5'd0, 2'd0, 5'd9, 2'd1, 1'b0, 1'b0);
        vecs[6]  = mk(5'd5, 5'd0, 2'd1, 2'd3, 1'b0, 5'd0, 2'd0, 5'd5, 2'd2, 1'b0, 1'b1);
        vecs[7]  = mk(5'd5, 5'd0, 2'd0, 2'd3, 1'b0, 5'd6, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0);
        vecs[8]  = mk(5'd0, 5'd0, 2'd3, 2'd3, 1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 1'b1, 1'b1);
        vecs[9]  = mk(5'd0, 5'd0, 2'd3, 2'd3, 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b1, 1'b0);
        vecs[10] = mk(5'd0, 5'd0, 2'd3, 2'd3, 1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0);
        vecs[11] = mk(5'd3, 5'd0, 2'd3, 2'd3, 1'b0, 5'd3, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0);

        // Reset held low throughout the table: sequencer stays idle even with starts applied.
        clear_inputs();
        reset = 1'b0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("reset_busy", 32'(md_busy), 32'd0);
        chk("reset_done", 32'(md_done), 32'd0);

        for (int i = 0; i < 12; i++) begin
            next_cycle();
            rs_D = vecs[i].rs; rt_D = vecs[i].rt;
            tuse_rs_D = vecs[i].tuse_rs; tuse_rt_D = vecs[i].tuse_rt;
            md_D = vecs[i].md; dst_E = vecs[i].de; tnew_E = vecs[i].te;
            dst_M = vecs[i].dm; tnew_M = vecs[i].tm; md_start_E = vecs[i].start;
            @(negedge clk);
            chk($sformatf("vec%0d_stall", i), 32'(stall), 32'(vecs[i].exp_stall));
            chk($sformatf("vec%0d_flush", i), 32'(flush_E), 32'(vecs[i].exp_stall));
            chk($sformatf("vec%0d_busy", i), 32'(md_busy), 32'd0);
        end

        // Mult latency, start-while-busy ignored, back-to-back restart.
        next_cycle();
        clear_inputs();
        reset = 1'b1;
        next_cycle();
        md_start_E = 1'b1; md_op_E = 1'b0;
        @(negedge clk);
        chk("mult_c0_busy", 32'(md_busy), 32'd0);
        for (int k = 1; k <= 12; k++) begin
            next_cycle();
            md_start_E = (k == 2) || (k == 6);
            md_op_E    = (k == 2);
            @(negedge clk);
            chk($sformatf("mult_c%0d_busy", k), 32'(md_busy),
                32'(((k >= 1) && (k <= 5)) || ((k >= 7) && (k <= 11))));
            chk($sformatf("mult_c%0d_done", k), 32'(md_done), 32'((k == 5) || (k == 11)));
        end

        // Div with mflo waiting in D.
        next_cycle();
        clear_inputs();
        md_start_E = 1'b1; md_op_E = 1'b1;
        @(negedge clk);
        chk("div_c0_stall", 32'(stall), 32'd0);
        for (int k = 1; k <= 11; k++) begin
            next_cycle();
            md_start_E = 1'b0; md_D = 1'b1;
            @(negedge clk);
            chk($sformatf("div_c%0d_stall", k), 32'(stall), 32'(k <= 10));
            chk($sformatf("div_c%0d_flush", k), 32'(flush_E), 32'(k <= 10));
            chk($sformatf("div_c%0d_done", k), 32'(md_done), 32'(k == 10));
        end

        // Reset mid-div, start ignored under reset, then a fresh mult.
        next_cycle();
        clear_inputs();
        md_start_E = 1'b1; md_op_E = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= 13; k++) begin
            next_cycle();
            reset      = !((k == 4) || (k == 5));
            md_start_E = (k == 5) || (k == 7);
            md_op_E    = (k == 5);
            @(negedge clk);
            chk($sformatf("rst_c%0d_busy", k), 32'(md_busy),
                32'((k <= 4) || ((k >= 8) && (k <= 12))));
            chk($sformatf("rst_c%0d_done", k), 32'(md_done), 32'(k == 12));
        end

`ifdef PIPE_STALL_CNT_EN
        next_cycle();
        clear_inputs();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            reset = 1'b1;
            set_load_use();
        end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        chk("cnt_after3", stall_cnt, 32'd3);
        next_cycle();
        reset = 1'b0;
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        chk("cnt_after_reset", stall_cnt, 32'd0);
        for (int k = 0; k < 2; k++) begin
            next_cycle();
            set_load_use();
        end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        chk("cnt_after2", stall_cnt, 32'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
